apb_master_gen: RTL and testbench

Parametrised APB4 master that converts a valid/ready command stream into APB transfers and returns a one-cycle response pulse per transfer. It replaces the fixed 8-bit single-address master in the peripheral bus path and adds configurable widths, byte strobes, slave-error reporting, back-to-back issue and an optional wait-state timeout. It sits between the system-side command source (CPU bridge or test sequencer) and the APB slave fabric.

---
 rtl/apb_master_gen.sv | 132 +++++++++++++
 tb/tb_apb_master_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_gen.sv
// APB4 master: turns a valid/ready command stream into APB transfers with a one-cycle response pulse.
// Optional wait-state timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_gen #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   abort;

  assign complete = (state == ACCESS) && pready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cmd_ready = rst && ((state == IDLE) || complete);
    accept    = cmd_valid && cmd_ready;
    busy      = (state != IDLE);
    psel      = 1'b0;
    penable   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (complete)   state_nxt = accept ? SETUP : IDLE;
        else if (abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Reads drive zero data and strobes so the slave never sees stale write bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb  : '0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_nxt == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !pready && (wait_cnt == CNT_MAX);
`else
  assign abort = 1'b0;
`endif

  // Response fields hold until the next pulse; only rsp_valid self-clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (complete) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_gen.sv
// Self-checking bench for apb_master_gen: directed APB scenarios plus randomized transfers
// against a transfer-level reference (latency = 2 + waits, abort when waits exceed TIMEOUT).
module tb_apb_master_gen;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_strb;
  logic              rsp_valid, rsp_err, rsp_timeout, busy;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;

  int total = 0;
  int bad   = 0;

  apb_master_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer from an idle master; the slave holds pready low for 'waits' ACCESS cycles.
  task automatic run_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic s,
                          input int waits, input logic err, input logic [7:0] rd);
    logic aborted;
    int   lat;
    bit   seen;
    aborted = TO_EN && (waits > TIMEOUT);
    seen    = 1'b0;
    lat     = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    pready = 1'b0; pslverr = 1'b0; prdata = 8'hEE;
    check("idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_busy", busy, 1);
    check("setup_paddr", paddr, a);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, wr ? d : 8'h00);
    check("setup_pstrb", pstrb, wr ? s : 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      lat = k;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check("acc_penable", penable, 1);
      check("acc_paddr", paddr, a);
      check("acc_pwdata", pwdata, wr ? d : 8'h00);
      check("acc_pstrb", pstrb, wr ? s : 1'b0);
      pready  = (k - 1 == waits);
      prdata  = pready ? rd : 8'hEE;
      pslverr = pready ? err : 1'b0;
    end
    pready = 1'b0; pslverr = 1'b0;
    check("rsp_seen", seen, 1);
    check("rsp_latency", lat, 2 + (aborted ? TIMEOUT : waits));
    check("rsp_rdata", rsp_rdata, (wr || aborted) ? 8'h00 : rd);
    check("rsp_err", rsp_err, aborted ? 1'b1 : err);
    check("rsp_timeout", rsp_timeout, aborted);
    check("done_psel", psel, 0);
    check("done_busy", busy, 0);
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
    check("rsp_hold", rsp_rdata, (wr || aborted) ? 8'h00 : rd);
  endtask

  initial begin
    logic [7:0] ra, rd_v, wd;
    logic       rw;
    int         rwait;

    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #2;
    check("rst_psel", psel, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", cmd_ready, 1);

    // Zero-wait write, read with three waits, slave error on a write.
    run_xfer(1'b1, 8'h3C, 8'hA5, 1'b1, 0, 1'b0, 8'h00);
    run_xfer(1'b0, 8'h10, 8'h77, 1'b1, 3, 1'b0, 8'h5A);
    run_xfer(1'b1, 8'h44, 8'h12, 1'b1, 1, 1'b1, 8'h00);

    // Back-to-back write then read with cmd_valid held across the handoff.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'hC3; cmd_strb = 1'b1;
    pready = 1'b1; prdata = 8'h00; pslverr = 1'b0;
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'hFF;
    check("b2b_setup1_penable", penable, 0);
    check("b2b_setup1_ready", cmd_ready, 0);
    @(negedge clk);
    prdata = 8'h96;
    check("b2b_access1_penable", penable, 1);
    check("b2b_access1_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_rsp1", rsp_valid, 1);
    check("b2b_rsp1_rdata", rsp_rdata, 8'h00);
    check("b2b_setup2_psel", psel, 1);
    check("b2b_setup2_penable", penable, 0);
    check("b2b_setup2_paddr", paddr, 8'h22);
    check("b2b_setup2_pwdata", pwdata, 8'h00);
    @(negedge clk);
    check("b2b_gap", rsp_valid, 0);
    check("b2b_access2_penable", penable, 1);
    @(negedge clk);
    pready = 1'b0;
    check("b2b_rsp2", rsp_valid, 1);
    check("b2b_rsp2_rdata", rsp_rdata, 8'h96);
    check("b2b_end_psel", psel, 0);

    // Timeout boundary: pready low through the abort edge, then rising exactly on that edge.
    if (TO_EN) begin
      run_xfer(1'b0, 8'h50, 8'h00, 1'b0, 20, 1'b0, 8'h3F);
      run_xfer(1'b0, 8'h51, 8'h00, 1'b0, TIMEOUT, 1'b0, 8'h3F);
    end

    // Randomized transfers, waits kept under the timeout threshold.
    for (int n = 0; n < 24; n++) begin
      rw    = 1'($urandom_range(0, 1));
      ra    = 8'($urandom);
      wd    = 8'($urandom);
      rd_v  = 8'($urandom);
      rwait = int'($urandom_range(0, 3));
      run_xfer(rw, ra, wd, 1'($urandom_range(0, 1)), rwait, 1'($urandom_range(0, 1)), rd_v);
    end

    // Reset asserted mid-ACCESS after a read left nonzero response data.
    run_xfer(1'b0, 8'h66, 8'h00, 1'b0, 0, 1'b1, 8'hC7);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h7E; cmd_wdata = 8'h81; cmd_strb = 1'b1;
    pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", penable, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_paddr", paddr, 0);
    check("mid_rst_pwdata", pwdata, 0);
    check("mid_rst_pwrite", pwrite, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_err", rsp_err, 0);
    pready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pready = 1'b0;
    #1;
    check("rel_busy", busy, 0);
    check("rel_ready", cmd_ready, 1);
    @(negedge clk);
    check("rel_no_rsp", rsp_valid, 0);
    check("rel_psel", psel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
